a2d_round_robin: RTL
====================

# a2d_round_robin

Sequencer for the ebike's 12-bit SPI A2D (ADC128S-class slave), acting as its SPI master. It scans four configured analog channels (battery, current, brake, torque) in fixed round-robin order and holds the latest 12-bit result for each. It sits between the A2D pins and the sensor-conditioning and PID logic. Each conversion uses two 16-bit SPI transactions: the first selects the channel, the second returns its result.

## Interface
- `CH_BATT` default 3'd0: A2D channel of battery voltage (slot 0)
- `CH_CURR` default 3'd1: A2D channel of motor current (slot 1)
- `CH_BRAKE` default 3'd3: A2D channel of brake lever (slot 2)
- `CH_TORQ` default 3'd4: A2D channel of torque sensor (slot 3)
- `ROUND_GAP` default 4096: idle clk cycles between the end of one round and the start of the next
- `clk` input 1: system clock; one clock domain only
- `rst` input 1: asynchronous, active-high reset
- `meas_req` input 1: single-cycle pulse that ends the current gap early and starts a round
- `MISO` input 1: serial data from the A2D
- `SS_n` output 1: active-low slave select
- `SCLK` output 1: serial clock, clk/32, idles high
- `MOSI` output 1: serial data to the A2D
- `batt`, `curr`, `brake`, `torque` output 12 each: latest result per slot
- `res_vld` output 1: one-cycle pulse when a slot result updates
- `res_slot` output 2: slot index qualifying `res_vld`
- `round_done` output 1: one-cycle pulse after slot 3 updates

## Operation
- **Reset values:** SS_n=1, SCLK=1, MOSI=0, all results 12'h000, res_vld=0, res_slot=0, round_done=0. After reset the state is GAP with the gap counter at 0.
- **States:** GAP → XFER_SEL → SPACE → XFER_RD → STORE → (next slot: XFER_SEL | after slot 3: GAP).
- **GAP:** counts ROUND_GAP cycles, then moves to XFER_SEL with slot=0. A `meas_req` seen in GAP moves to XFER_SEL on the next cycle. A `meas_req` outside GAP is ignored and is not queued.
- **Command word:** {2'b00, CH_x[2:0], 11'h000}, where CH_x is the channel of the current slot. XFER_SEL and XFER_RD send the identical word.
- **Received data:** the word received in XFER_SEL is discarded. In XFER_RD the received word's bits [11:0] are the result for the slot; bits [15:12] are ignored.
- **SPACE:** SS_n is held high for exactly 4 clk between the two transactions.
- **STORE:** one cycle. It writes the slot's result register, pulses res_vld with res_slot=slot, then increments slot. After slot 3 it also pulses round_done in the same cycle, clears slot to 0 and enters GAP with the counter cleared.
- Slot order is always 0, 1, 2, 3. No slot is ever skipped.

## Timing
SPI transaction, mode 3:
- A 5-bit divider is loaded to 5'b10111 on the clk where SS_n falls. SCLK = divider[4].
- SCLK first falls 8 clk after SS_n falls. After that the period is 32 clk at 50% duty.
- MOSI presents cmd[15] from the SS_n fall. MOSI shifts to the next bit on each SCLK fall except the first.
- The slave samples MOSI on SCLK rise. MISO is sampled into the rx shift register on the clk where SCLK rises.
- Each transaction has exactly 16 SCLK rises, MSB first.
- After the 16th rise, SCLK stays high, and SS_n rises 14 clk later.
- SS_n low time per transaction is 8 + 15×32 + 16 + 14 = 518 clk.

Round timing:
- One slot takes 518 + 4 + 518 + 1 (STORE) cycles. A new XFER_SEL starts SS_n low on the cycle after STORE.
- Result register update and res_vld both occur on the STORE clk edge, i.e. 1 clk after SS_n rises for XFER_RD.

Boundary cases:
- `rst` during a transaction: SS_n=1 and SCLK=1 asynchronously; partial data is discarded; result registers clear.
- `meas_req` on the last GAP cycle is equivalent to a normal GAP expiry; the round starts once.
- ROUND_GAP=0 (legal): rounds run back-to-back.

## Test plan
- **Reset mid-transaction:** assert rst at the 7th SCLK rise of XFER_RD on slot 1 → SS_n=1, SCLK=1 in the same cycle; all results 0. After release, the next round starts at slot 0 following ROUND_GAP cycles.
- **Round order and commands:** with the SPI_ADC128S model driving A2D_data=16'hF123, run one round after reset → slave `cmd` captures 16'h0000, 16'h0800, 16'h1800, 16'h2000 in slot order. batt=curr=brake=torque=12'h123; res_slot pulses 0, 1, 2, 3; round_done occurs once.
- **SPI waveform:** measure the first transaction → the first SCLK fall is 8 clk after SS_n falls, the period is 32, there are exactly 16 rises, and SS_n is low for 518 clk. SS_n is high for 4 clk between XFER_SEL and XFER_RD.
- **Per-slot values:** change A2D_data per transaction to 16'h0AAA, 16'h0555, 16'h0FFF, 16'h0001 → each value lands in the slot whose XFER_RD it was captured in. The discarded XFER_SEL data never appears on any output.
- **meas_req behaviour:** with ROUND_GAP=4096, pulse meas_req 100 cycles into GAP → SS_n falls 1 cycle later. A meas_req during XFER_RD causes no extra round.

Source files
------------

// File: rtl/a2d_round_robin_if.sv
// SPI pin bundle between the round-robin A2D sequencer (master) and the ADC (slave).
interface a2d_round_robin_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output SCLK, output MOSI, input MISO);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/a2d_round_robin.sv
// Round-robin SPI master for the 12-bit A2D: scans battery, current, brake and torque
// channels, two 16-bit mode-3 transactions per slot, and holds the latest result of each.
module a2d_round_robin #(
  parameter logic [2:0]  CH_BATT   = 3'd0,
  parameter logic [2:0]  CH_CURR   = 3'd1,
  parameter logic [2:0]  CH_BRAKE  = 3'd3,
  parameter logic [2:0]  CH_TORQ   = 3'd4,
  parameter int unsigned ROUND_GAP = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                meas_req,
  a2d_round_robin_if.master   a2d,
  output logic [11:0]         batt,
  output logic [11:0]         curr,
  output logic [11:0]         brake,
  output logic [11:0]         torque,
  output logic                res_vld,
  output logic [1:0]          res_slot,
  output logic                round_done
);

  localparam logic [2:0] GAP      = 3'd0;
  localparam logic [2:0] XFER_SEL = 3'd1;
  localparam logic [2:0] SPACE    = 3'd2;
  localparam logic [2:0] XFER_RD  = 3'd3;
  localparam logic [2:0] STORE    = 3'd4;

  localparam logic [4:0]  DIV_IDLE = 5'b10111;
  localparam int unsigned GW       = (ROUND_GAP > 1) ? $clog2(ROUND_GAP) : 1;

  logic [2:0]    state, state_nxt;
  logic [GW-1:0] gap_cnt;
  logic [1:0]    space_cnt;
  logic [1:0]    slot, slot_nxt;
  logic [4:0]    div;
  logic [4:0]    bit_cnt;
  logic [15:0]   tx_sh;
  logic [11:0]   rx_sh;
  logic          ss_n;
  logic          start, xfer, xfer_done, gap_last, sclk_rise, sclk_fall;

  function automatic logic [15:0] cmd_word(input logic [1:0] s);
    logic [2:0] ch;
    case (s)
      2'd0:    ch = CH_BATT;
      2'd1:    ch = CH_CURR;
      2'd2:    ch = CH_BRAKE;
      default: ch = CH_TORQ;
    endcase
    return {2'b00, ch, 11'h000};
  endfunction

  assign xfer      = (state == XFER_SEL) || (state == XFER_RD);
  assign sclk_rise = xfer && (div == 5'd15);
  assign sclk_fall = xfer && (div == 5'd31);
  // 16th rise leaves div at 16; SCLK stays high while it runs to 29, so SS_n rises 14 clk later.
  assign xfer_done = xfer && (bit_cnt == 5'd16) && (div == 5'd29);
  assign gap_last  = (32'(gap_cnt) + 32'd1) >= ROUND_GAP;

  assign a2d.SS_n = ss_n;
  assign a2d.SCLK = div[4];
  assign a2d.MOSI = tx_sh[15];

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      GAP: begin
        if (meas_req || gap_last) begin
          state_nxt = XFER_SEL;
          start     = 1'b1;
        end
      end
      XFER_SEL: if (xfer_done) state_nxt = SPACE;
      SPACE: begin
        if (space_cnt == 2'd3) begin
          state_nxt = XFER_RD;
          start     = 1'b1;
        end
      end
      XFER_RD: if (xfer_done) state_nxt = STORE;
      STORE: begin
        if ((slot == 2'd3) && (ROUND_GAP != 0)) begin
          state_nxt = GAP;
        end else begin
          state_nxt = XFER_SEL;
          start     = 1'b1;
        end
      end
      default: state_nxt = GAP;
    endcase
    slot_nxt = (state == STORE) ? slot + 2'd1 : slot;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= GAP;
      gap_cnt    <= '0;
      space_cnt  <= '0;
      slot       <= '0;
      div        <= DIV_IDLE;
      bit_cnt    <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      ss_n       <= 1'b1;
      batt       <= '0;
      curr       <= '0;
      brake      <= '0;
      torque     <= '0;
      res_vld    <= 1'b0;
      res_slot   <= '0;
      round_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      slot       <= slot_nxt;
      res_vld    <= 1'b0;
      round_done <= 1'b0;
      gap_cnt    <= (state == GAP && !start) ? gap_cnt + 1'b1 : '0;
      space_cnt  <= (state == SPACE) ? space_cnt + 2'd1 : 2'd0;

      // The divider idles at 10111 and starts stepping on the SS_n fall, so SCLK falls 8 clk later.
      if (start) begin
        ss_n    <= 1'b0;
        tx_sh   <= cmd_word(slot_nxt);
        bit_cnt <= '0;
        div     <= div + 5'd1;
      end else if (xfer) begin
        if (xfer_done) begin
          ss_n <= 1'b1;
          div  <= DIV_IDLE;
        end else begin
          div <= div + 5'd1;
        end
        if (sclk_rise) begin
          bit_cnt <= bit_cnt + 5'd1;
          rx_sh   <= {rx_sh[10:0], a2d.MISO};
        end
        if (sclk_fall && (bit_cnt != 5'd0)) tx_sh <= {tx_sh[14:0], 1'b0};
      end

      if (state == STORE) begin
        case (slot)
          2'd0:    batt   <= rx_sh;
          2'd1:    curr   <= rx_sh;
          2'd2:    brake  <= rx_sh;
          default: torque <= rx_sh;
        endcase
        res_vld  <= 1'b1;
        res_slot <= slot;
        if (slot == 2'd3) round_done <= 1'b1;
      end
    end
  end

endmodule
